// File: rtl/kmeans_iter_ctrl_if.sv
// ============================================================================
// Module   : kmeans_iter_ctrl_if
// Purpose  : Bundle of the k-means iteration controller's handshake, sum-RAM
//            readback and centroid/status signals. The master modport is the
//            controller; the slave modport is the datapath/host side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kmeans_iter_ctrl_if #(
   parameter int data_width    = 8,
   parameter int acc_sum_width = 16,
   parameter int cnt_width     = 9
);
   logic                     start;
   logic                     pass_start;
   logic                     pass_done;
   logic                     bck_rd;
   logic                     bck_rd_addr;
   logic [acc_sum_width-1:0] sum_d0;
   logic [acc_sum_width-1:0] sum_d1;
   logic [cnt_width-1:0]     cnt_k0;
   logic [cnt_width-1:0]     cnt_k1;
   logic [data_width-1:0]    k0_0;
   logic [data_width-1:0]    k0_1;
   logic [data_width-1:0]    k1_0;
   logic [data_width-1:0]    k1_1;
   logic                     up_centroids;
   logic                     busy;
   logic                     done;
   logic                     converged;
   logic [4:0]               iter_count;

   modport master (
      input  start, pass_done, sum_d0, sum_d1, cnt_k0, cnt_k1,
      output pass_start, bck_rd, bck_rd_addr, k0_0, k0_1, k1_0, k1_1,
             up_centroids, busy, done, converged, iter_count
   );

   modport slave (
      output start, pass_done, sum_d0, sum_d1, cnt_k0, cnt_k1,
      input  pass_start, bck_rd, bck_rd_addr, k0_0, k0_1, k1_0, k1_1,
             up_centroids, busy, done, converged, iter_count
   );
endinterface

`default_nettype wire

// File: rtl/kmeans_iter_ctrl.sv
// ============================================================================
// Module   : kmeans_iter_ctrl
// Purpose  : Iteration controller for a 2-cluster, 2-D k-means engine. Runs
//            classification passes, reads back per-cluster sums and counts,
//            divides them with a restoring divider and updates the centroids.
// Option   : KMEANS_CTRL_CONV_EN - early exit when a pass leaves all four
//            centroids unchanged (otherwise every run does max_iter passes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kmeans_iter_ctrl #(
   parameter int data_width    = 8,
   parameter int acc_sum_width = 16,
   parameter int cnt_width     = 9,
   parameter int max_iter      = 16,
   parameter int p_k0_0        = 0,
   parameter int p_k0_1        = 0,
   parameter int p_k1_0        = 1,
   parameter int p_k1_1        = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   kmeans_iter_ctrl_if.master bus
);
   localparam int c_sw = (acc_sum_width > 1) ? $clog2(acc_sum_width) : 1;
   localparam logic [acc_sum_width-1:0] c_qmax = acc_sum_width'((1 << data_width) - 1);

   typedef enum logic [2:0] {
      IDLE, PASS, RD, DIV, NEXT, UPD, CHECK, DONE
   } state_t;

   state_t                   state_q;
   logic                     c_q;
   logic                     pass_start_q, bck_rd_q, bck_rd_addr_q;
   logic                     up_q, busy_q, done_q;
   logic [4:0]               iter_q;
   logic [data_width-1:0]    k00_q, k01_q, k10_q, k11_q;
   logic [data_width-1:0]    n00_q, n01_q, n10_q, n11_q;
   logic [acc_sum_width-1:0] dvd_q, sum1_q;
   logic [cnt_width-1:0]     rem_q, div_q;
   logic [c_sw-1:0]          step_q;
   logic                     phase_q;
`ifdef KMEANS_CTRL_CONV_EN
   logic                     conv_q;
`endif

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   logic [cnt_width:0]       rem_sh, rem_sub;
   logic                     q_bit;
   logic [cnt_width-1:0]     rem_d;
   logic [acc_sum_width-1:0] dvd_d;
   logic                     step_last;

   assign rem_sh    = {rem_q, dvd_q[acc_sum_width-1]};
   assign rem_sub   = rem_sh - {1'b0, div_q};
   assign q_bit     = (rem_sh >= {1'b0, div_q});
   assign rem_d     = q_bit ? rem_sub[cnt_width-1:0] : rem_sh[cnt_width-1:0];
   assign dvd_d     = {dvd_q[acc_sum_width-2:0], q_bit};
   assign step_last = (step_q == c_sw'(acc_sum_width - 1));

   // Quotients wider than a coordinate clip to the largest coordinate.
   function automatic logic [data_width-1:0] sat(input logic [acc_sum_width-1:0] q);
      if (q > c_qmax) return '1;
      return q[data_width-1:0];
   endfunction

   // Controller FSM with all outputs registered; reset abandons any partial quotient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         c_q           <= 1'b0;
         pass_start_q  <= 1'b0;
         bck_rd_q      <= 1'b0;
         bck_rd_addr_q <= 1'b0;
         up_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         iter_q        <= '0;
         k00_q         <= data_width'(p_k0_0);
         k01_q         <= data_width'(p_k0_1);
         k10_q         <= data_width'(p_k1_0);
         k11_q         <= data_width'(p_k1_1);
         n00_q         <= data_width'(p_k0_0);
         n01_q         <= data_width'(p_k0_1);
         n10_q         <= data_width'(p_k1_0);
         n11_q         <= data_width'(p_k1_1);
         dvd_q         <= '0;
         sum1_q        <= '0;
         rem_q         <= '0;
         div_q         <= '0;
         step_q        <= '0;
         phase_q       <= 1'b0;
`ifdef KMEANS_CTRL_CONV_EN
         conv_q        <= 1'b0;
`endif
      end else begin
         pass_start_q <= 1'b0;
         up_q         <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  iter_q       <= '0;
`ifdef KMEANS_CTRL_CONV_EN
                  conv_q       <= 1'b0;
`endif
                  busy_q       <= 1'b1;
                  pass_start_q <= 1'b1;
                  state_q      <= PASS;
               end
            end
            PASS: begin
               if (bus.pass_done) begin
                  c_q           <= 1'b0;
                  bck_rd_q      <= 1'b1;
                  bck_rd_addr_q <= 1'b0;
                  state_q       <= RD;
               end
            end
            RD: begin
               // Stage the old centroid so an empty cluster simply keeps it.
               if (c_q) begin
                  n10_q <= k10_q;
                  n11_q <= k11_q;
               end else begin
                  n00_q <= k00_q;
                  n01_q <= k01_q;
               end
               dvd_q   <= bus.sum_d0;
               sum1_q  <= bus.sum_d1;
               div_q   <= c_q ? bus.cnt_k1 : bus.cnt_k0;
               rem_q   <= '0;
               step_q  <= '0;
               phase_q <= 1'b0;
               state_q <= DIV;
            end
            DIV: begin
               if (div_q == '0) begin
                  bck_rd_q <= 1'b0;
                  state_q  <= NEXT;
               end else begin
                  dvd_q  <= dvd_d;
                  rem_q  <= rem_d;
                  step_q <= step_q + 1'b1;
                  if (step_last) begin
                     if (!phase_q) begin
                        if (c_q) n10_q <= sat(dvd_d);
                        else     n00_q <= sat(dvd_d);
                        dvd_q   <= sum1_q;
                        rem_q   <= '0;
                        step_q  <= '0;
                        phase_q <= 1'b1;
                     end else begin
                        if (c_q) n11_q <= sat(dvd_d);
                        else     n01_q <= sat(dvd_d);
                        bck_rd_q <= 1'b0;
                        state_q  <= NEXT;
                     end
                  end
               end
            end
            NEXT: begin
               if (!c_q) begin
                  c_q           <= 1'b1;
                  bck_rd_q      <= 1'b1;
                  bck_rd_addr_q <= 1'b1;
                  state_q       <= RD;
               end else begin
                  state_q <= UPD;
               end
            end
            UPD: begin
               k00_q <= n00_q;
               k01_q <= n01_q;
               k10_q <= n10_q;
               k11_q <= n11_q;
               up_q  <= 1'b1;
               if (iter_q != 5'd31) iter_q <= iter_q + 5'd1;
`ifdef KMEANS_CTRL_CONV_EN
               conv_q <= (n00_q == k00_q) && (n01_q == k01_q) &&
                         (n10_q == k10_q) && (n11_q == k11_q);
`endif
               state_q <= CHECK;
            end
            CHECK: begin
`ifdef KMEANS_CTRL_CONV_EN
               if (conv_q || (int'(iter_q) == max_iter)) begin
`else
               if (int'(iter_q) == max_iter) begin
`endif
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  pass_start_q <= 1'b1;
                  state_q      <= PASS;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pass_start   = pass_start_q;
   assign bus.bck_rd       = bck_rd_q;
   assign bus.bck_rd_addr  = bck_rd_addr_q;
   assign bus.k0_0         = k00_q;
   assign bus.k0_1         = k01_q;
   assign bus.k1_0         = k10_q;
   assign bus.k1_1         = k11_q;
   assign bus.up_centroids = up_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.iter_count   = iter_q;
`ifdef KMEANS_CTRL_CONV_EN
   assign bus.converged    = conv_q;
`else
   assign bus.converged    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kmeans_iter_ctrl.sv
// ============================================================================
// Module   : tb_kmeans_iter_ctrl
// Purpose  : Directed self-checking bench for kmeans_iter_ctrl: reset state,
//            one iteration, divide latency, empty cluster, saturation,
//            run length / convergence and reset in the middle of a divide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kmeans_iter_ctrl;
`ifdef KMEANS_CTRL_CONV_EN
   localparam int  n_passes = 2;
   localparam logic conv_exp = 1'b1;
`else
   localparam int  n_passes = 16;
   localparam logic conv_exp = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   kmeans_iter_ctrl_if bus ();

   kmeans_iter_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Sum RAM / count model, read asynchronously through bck_rd_addr.
   logic [15:0] s00, s01, s10, s11;
   logic [8:0]  c0, c1;
   assign bus.sum_d0 = bus.bck_rd_addr ? s10 : s00;
   assign bus.sum_d1 = bus.bck_rd_addr ? s11 : s01;
   assign bus.cnt_k0 = c0;
   assign bus.cnt_k1 = c1;

   // Pulse counters sampled on the falling edge.
   int n_ps = 0, n_up = 0, n_done = 0;
   always @(negedge clk) begin
      if (bus.pass_start)   n_ps   <= n_ps + 1;
      if (bus.up_centroids) n_up   <= n_up + 1;
      if (bus.done)         n_done <= n_done + 1;
   end

   int tests = 0, failed = 0;
   int ps_used = 0, done_used = 0;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_k(input string tag, input int a, input int b, input int c, input int d);
      chk({tag, "_k0_0"}, 32'(bus.k0_0), a);
      chk({tag, "_k0_1"}, 32'(bus.k0_1), b);
      chk({tag, "_k1_0"}, 32'(bus.k1_0), c);
      chk({tag, "_k1_1"}, 32'(bus.k1_1), d);
   endtask

   task automatic wait_ps(output bit got_ps, output bit got_done);
      got_ps = 1'b0;
      got_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (n_ps > ps_used) begin
            ps_used++;
            got_ps = 1'b1;
            return;
         end
         if (n_done > done_used) begin
            done_used++;
            got_done = 1'b1;
            return;
         end
         tick();
      end
   endtask

   // Pulse pass_done during PASS; lat counts clock edges from the edge that
   // samples pass_done to the edge that raises up_centroids.
   task automatic fire_pass(output int lat);
      bus.pass_done = 1'b1;
      tick();
      bus.pass_done = 1'b0;
      chk("rd_strobe", 32'(bus.bck_rd), 1);
      chk("rd_addr0", 32'(bus.bck_rd_addr), 0);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         lat++;
         if (bus.up_centroids) break;
      end
      chk("up_seen", 32'(bus.up_centroids), 1);
   endtask

   task automatic pass_step(output int lat);
      bit p, d;
      wait_ps(p, d);
      chk("pass_start_seen", 32'(p), 1);
      lat = 0;
      if (p) fire_pass(lat);
   endtask

   task automatic expect_done();
      bit p, d;
      wait_ps(p, d);
      chk("done_seen", 32'(d), 1);
   endtask

   task automatic start_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("busy_on", 32'(bus.busy), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int u0;
      int ps0;
      bit p, d;

      bus.start = 1'b0;
      bus.pass_done = 1'b0;
      s00 = '0; s01 = '0; s10 = '0; s11 = '0; c0 = '0; c1 = '0;

      // Reset values
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk_k("rst", 0, 0, 1, 1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_conv", 32'(bus.converged), 0);
      chk("rst_iter", 32'(bus.iter_count), 0);
      chk("rst_ps", 32'(bus.pass_start), 0);
      chk("rst_bckrd", 32'(bus.bck_rd), 0);
      chk("rst_up", 32'(bus.up_centroids), 0);
      repeat (4) tick();
      chk("idle_no_ps", 32'(n_ps), 0);

      // Run A: one iteration, latency, then run length / convergence
      s00 = 30; s01 = 60; c0 = 3;
      s10 = 40; s11 = 20; c1 = 4;
      start_run();
      chk("start_ps", 32'(bus.pass_start), 1);
      u0 = n_up;
      pass_step(lat);
      chk("lat_full", 32'(lat), 69);
      chk_k("iter1", 10, 20, 10, 5);
      chk("iter1_cnt", 32'(bus.iter_count), 1);
      tick();
      chk("up_low", 32'(bus.up_centroids), 0);
      chk("up_once", 32'(n_up - u0), 1);
      bus.start = 1'b1;           // ignored while busy
      tick();
      bus.start = 1'b0;
      pass_step(lat);
      chk("iter2_cnt", 32'(bus.iter_count), 2);
      chk_k("iter2", 10, 20, 10, 5);
      for (int i = 3; i <= n_passes; i++) pass_step(lat);
      expect_done();
      chk("runA_iter", 32'(bus.iter_count), n_passes);
      chk("runA_conv", 32'(bus.converged), 32'(conv_exp));
      tick();
      chk("runA_busy_off", 32'(bus.busy), 0);

      // Run B: empty cluster, saturation, then reset mid-divide
      s00 = 100; s01 = 50; c0 = 5;
      s10 = 50;  s11 = 50; c1 = 0;
      start_run();
      chk("runB_conv_clr", 32'(bus.converged), 0);
      pass_step(lat);
      chk("lat_empty", 32'(lat), 38);
      chk_k("empty", 20, 10, 10, 5);
      s00 = 3000; s01 = 7;   c0 = 1;
      s10 = 9;    s11 = 255; c1 = 2;
      pass_step(lat);
      chk("lat_sat", 32'(lat), 69);
      chk_k("sat", 255, 7, 4, 127);
      wait_ps(p, d);
      chk("pass3_ps", 32'(p), 1);
      bus.pass_done = 1'b1;
      tick();
      bus.pass_done = 1'b0;
      repeat (10) tick();
      chk("div_bckrd", 32'(bus.bck_rd), 1);
      rst_n = 1'b0;
      #1;
      chk_k("midrst", 0, 0, 1, 1);
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_iter", 32'(bus.iter_count), 0);
      chk("midrst_bckrd", 32'(bus.bck_rd), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      ps0 = n_ps;
      repeat (5) tick();
      chk("postrst_idle_ps", 32'(n_ps - ps0), 0);
      chk("postrst_busy", 32'(bus.busy), 0);
      ps_used = n_ps;
      done_used = n_done;

      // Run C: normal run after the mid-divide reset
      s00 = 30; s01 = 60; c0 = 3;
      s10 = 40; s11 = 20; c1 = 4;
      start_run();
      pass_step(lat);
      chk("runC_lat", 32'(lat), 69);
      chk_k("runC", 10, 20, 10, 5);
      chk("runC_iter1", 32'(bus.iter_count), 1);
      for (int i = 2; i <= n_passes; i++) pass_step(lat);
      expect_done();
      chk("runC_iter", 32'(bus.iter_count), n_passes);
      chk("runC_conv", 32'(bus.converged), 32'(conv_exp));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

`default_nettype wire
